// File: rtl/lcd_cmd_arbiter.sv
// Round-robin arbiter that shares one 6x6 LCD display engine between two requesters.
// It buffers LoadData images, issues commands, streams pixels and routes window bytes back to the owner.
module lcd_cmd_arbiter #(
  parameter int IMG_BYTES = 36,
  parameter int WIN_BYTES = 9,
  parameter int TIMEOUT   = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [2:0] req_cmd0,
  input  logic [2:0] req_cmd1,
  input  logic [7:0] din0,
  input  logic [7:0] din1,
  input  logic [1:0] din_valid,
  output logic [1:0] gnt,
  output logic [7:0] resp_data,
  output logic [1:0] resp_valid,
  output logic [1:0] done,
  output logic [1:0] err,
  output logic [2:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  output logic [7:0] lcd_datain,
  input  logic       lcd_busy,
  input  logic [7:0] lcd_dataout,
  input  logic       lcd_output_valid
);

  localparam logic [5:0] LAST_IMG = 6'(IMG_BYTES - 1);
  localparam logic [3:0] WIN_CNT  = 4'(WIN_BYTES);
  localparam logic [5:0] TO_CNT   = 6'(TIMEOUT);
  localparam logic [2:0] CMD_LOAD = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_REJECT, S_FILL, S_ISSUE, S_STREAM, S_COLLECT
  } state_t;

  state_t     state, state_nx;
  logic       owner;
  logic       rr_ptr;
  logic [2:0] cmd;
  logic [5:0] fill_cnt;
  logic [5:0] stream_cnt;
  logic [5:0] idle_cnt;
  logic [3:0] out_cnt;
  logic [7:0] buffer [IMG_BYTES];

  logic       grant_en;
  logic       winner;
  logic [2:0] sel_cmd;
  logic       fill_en;
  logic [7:0] fill_byte;

  // With both requesting, the pointer decides; otherwise the sole requester wins.
  always_comb begin
    grant_en  = (state == S_IDLE) && (req != 2'b00) && !lcd_busy;
    winner    = (req == 2'b11) ? rr_ptr : req[1];
    sel_cmd   = winner ? req_cmd1 : req_cmd0;
    fill_en   = (state == S_FILL) && din_valid[owner];
    fill_byte = owner ? din1 : din0;
  end

  always_comb begin
    state_nx      = state;
    gnt           = 2'b00;
    err           = 2'b00;
    done          = 2'b00;
    resp_valid    = 2'b00;
    resp_data     = 8'h00;
    lcd_cmd       = 3'd0;
    lcd_cmd_valid = 1'b0;
    lcd_datain    = 8'h00;
    case (state)
      S_IDLE: begin
        if (grant_en) begin
          gnt = winner ? 2'b10 : 2'b01;
          if (sel_cmd > 3'd5)            state_nx = S_REJECT;
          else if (sel_cmd == CMD_LOAD)  state_nx = S_FILL;
          else                           state_nx = S_ISSUE;
        end
      end
      S_REJECT: begin
        err      = owner ? 2'b10 : 2'b01;
        state_nx = S_IDLE;
      end
      S_FILL: begin
        if (fill_en && fill_cnt == LAST_IMG) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        lcd_cmd_valid = 1'b1;
        lcd_cmd       = cmd;
        state_nx      = (cmd == CMD_LOAD) ? S_STREAM : S_COLLECT;
      end
      S_STREAM: begin
        lcd_datain = buffer[stream_cnt];
        if (stream_cnt == LAST_IMG) state_nx = S_COLLECT;
      end
      S_COLLECT: begin
        // Bytes past the window size are dropped silently.
        if (lcd_output_valid && out_cnt < WIN_CNT) begin
          resp_valid = owner ? 2'b10 : 2'b01;
          resp_data  = lcd_dataout;
        end
        if (out_cnt == WIN_CNT && !lcd_busy) begin
          done     = owner ? 2'b10 : 2'b01;
          state_nx = S_IDLE;
        end else if (idle_cnt == TO_CNT && !lcd_output_valid) begin
          err      = owner ? 2'b10 : 2'b01;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      cmd        <= 3'd0;
      fill_cnt   <= 6'd0;
      stream_cnt <= 6'd0;
      idle_cnt   <= 6'd0;
      out_cnt    <= 4'd0;
    end else begin
      state <= state_nx;
      if (grant_en) begin
        owner  <= winner;
        cmd    <= sel_cmd;
        rr_ptr <= ~winner;
      end
      if (fill_en) fill_cnt <= (fill_cnt == LAST_IMG) ? 6'd0 : fill_cnt + 6'd1;
      if (state == S_STREAM) stream_cnt <= (stream_cnt == LAST_IMG) ? 6'd0 : stream_cnt + 6'd1;
      if (state == S_ISSUE) begin
        idle_cnt <= 6'd0;
        out_cnt  <= 4'd0;
      end else if (state == S_COLLECT) begin
        if (lcd_output_valid) begin
          idle_cnt <= 6'd0;
          if (out_cnt < WIN_CNT) out_cnt <= out_cnt + 4'd1;
        end else begin
          idle_cnt <= idle_cnt + 6'd1;
        end
      end
    end
  end

  // Image storage needs no reset; it is always written before it is streamed.
  always_ff @(posedge clk) begin
    if (fill_en) buffer[fill_cnt] <= fill_byte;
  end

endmodule

// File: doc/lcd_cmd_arbiter.md
# lcd_cmd_arbiter

- Shares one 6x6-image LCD display engine between two requesters.
- Arbitrates their commands round-robin and buffers a requester's 36-byte image for LoadData.
- Issues each command to the engine over its cmd/cmd_valid/busy handshake and streams the image on consecutive cycles.
- Routes the engine's 9-byte 3x3 window output back to the requester that owns the command.

## Interface
Parameters:
- IMG_BYTES, 36, image size in bytes streamed for LoadData
- WIN_BYTES, 9, output bytes returned per command
- TIMEOUT, 63, max COLLECT cycles without lcd_output_valid before abort

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- req  in  2  req[i]: requester i has a command pending; held until gnt[i]
- req_cmd0  in  3  command of requester 0 (0 Reflash, 1 LoadData, 2 Right, 3 Left, 4 Up, 5 Down)
- req_cmd1  in  3  command of requester 1
- din0, din1  in  8  image bytes from requester 0 / 1
- din_valid  in  2  din_valid[i] qualifies din_i
- gnt  out  2  one-cycle one-hot pulse; cmd of requester i captured that cycle
- resp_data  out  8  window byte returned to owner
- resp_valid  out  2  one-hot, marks resp_data for requester i
- done  out  2  one-cycle pulse; owner's command complete
- err  out  2  one-cycle pulse; owner's command rejected or timed out
- lcd_cmd  out  3  command to engine
- lcd_cmd_valid  out  1  one-cycle issue strobe
- lcd_datain  out  8  image byte to engine
- lcd_busy  in  1  engine busy
- lcd_dataout  in  8  engine window byte
- lcd_output_valid  in  1  qualifies lcd_dataout

## Operation
- Reset:
  - All outputs 0; state IDLE.
  - Round-robin pointer favours requester 0.
  - All counters 0; buffer contents don't-care.
- IDLE:
  - Waits for req != 0 and lcd_busy == 0.
  - Winner: sole requester; if both request, the pointer side.
  - Pulses gnt[winner] and latches owner and cmd.
  - Pointer moves to the non-winner.
  - Next state:
    - cmd 6/7 -> REJECT.
    - LoadData -> FILL.
    - Otherwise -> ISSUE.
- REJECT: err[owner]=1 for one cycle, no engine activity -> IDLE.
- FILL:
  - Each cycle with din_valid[owner]=1, writes din_owner into buffer[fill_cnt] and increments fill_cnt (6-bit).
  - din_valid from the non-owner, or in any other state, is ignored.
  - After the byte at fill_cnt==35 -> ISSUE.
  - No timeout in FILL.
- ISSUE:
  - lcd_cmd_valid=1 and lcd_cmd=cmd for exactly one cycle.
  - LoadData -> STREAM; others -> COLLECT.
- STREAM:
  - In the k-th cycle after ISSUE (k=0..35), lcd_datain=buffer[k]; no gaps.
  - After k=35 -> COLLECT.
  - lcd_datain holds 0 outside STREAM.
- COLLECT:
  - Each cycle lcd_output_valid=1: resp_data=lcd_dataout and resp_valid[owner]=1, combinationally same cycle; out_cnt (4-bit) increments.
  - Once out_cnt==9 and lcd_busy==0: done[owner] pulses -> IDLE.
  - Idle counter (6-bit) resets on every lcd_output_valid.
  - If the counter reaches TIMEOUT: err[owner] pulses -> IDLE.
  - lcd_output_valid beyond the 9th byte is dropped, not forwarded.
- Reset mid-operation returns to IDLE immediately. No done/err is emitted for the aborted command.

## Timing
- Non-load command: gnt in cycle T, lcd_cmd_valid in T+1.
- LoadData:
  - gnt in T; FILL from T+1.
  - 36 back-to-back din_valid -> last byte at T+36, lcd_cmd_valid at T+37.
  - Stream bytes at T+38..T+73.
- done is at least 1 cycle after the 9th resp_valid.
- The next gnt is at earliest the cycle after done/err.
- req asserted in any non-IDLE state is not granted until IDLE.
- A requester re-asserting immediately after its own done loses to a pending other requester.

## Test plan
- Reset then idle:
  - All outputs 0 for 10 cycles with req=0.
  - Assert reset during STREAM: outputs 0 next cycle, no done.
- Single Reflash:
  - req=01, cmd0=0: gnt=01 at T, lcd_cmd_valid/lcd_cmd=0 at T+1.
  - Model engine returns bytes 0x10..0x18: resp_valid=01 with those 9 values, then done=01.
- LoadData from requester 1:
  - din1=0x00..0x23 on 36 consecutive valids: lcd_cmd=1 pulse.
  - lcd_datain=0x00..0x23 on 36 consecutive cycles.
  - 9 window bytes routed with resp_valid=10, then done=10.
- Contention:
  - req=11 held, both cmd=2: grants alternate 01,10,01,10 across four commands.
  - Each done goes to the correct requester.
- Invalid and timeout:
  - cmd0=7: gnt=01, err=01 next cycle, lcd_cmd_valid never asserts.
  - Engine silent after Up: err pulses after 63 idle cycles.
- Interleaved noise:
  - din_valid[0] toggling while requester 1 fills: buffer holds only din1 bytes.
  - A 10th lcd_output_valid is not forwarded.
